// File: rtl/shift_mult_seq.sv
// shift_mult_seq: iterative shift-and-add multiplier sequencer.
//
// Computes the low 32 bits of op_a * op_b by scanning the multiplier one bit
// per clock. Each RUN cycle it drives an external 32-bit combinational left
// shifter (sh_a / sh_s -> sh_out) with the multiplicand and the current bit
// index. When the indexed multiplier bit is set, the shifted value is added
// into the accumulator.
//
// Optional feature, selected by the macro SHIFT_MULT_EARLY_EXIT_EN:
//   defined     - RUN ends as soon as no set multiplier bits remain above the
//                 bit just processed.
//   not defined - all N_BITS multiplier bits are always scanned, so latency
//                 is fixed.
// The result is identical in both builds.
//
// Handshake: start is a request that is accepted only while the FSM is in
// IDLE. Any start seen while busy=1 is dropped, not queued. done is a
// one-cycle pulse, and result is valid from that cycle until the next
// accepted start. busy is high in RUN and DONE.
//
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers.

module shift_mult_seq #(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] sh_a,
  output logic [31:0] sh_s,
  input  logic [31:0] sh_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the last multiplier bit that is scanned.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);

  // Multiplier bits at or above N_BITS are cleared when op_b is latched.
  localparam logic [31:0] B_MASK = (N_BITS >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << N_BITS) - 32'd1);

  state_t           state_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      result_q;

  logic [31:0]      addend_d;
  logic [31:0]      acc_d;
  logic             last_d;

  // Addend for this cycle and the accumulator value after the current bit.
  always_comb begin
    addend_d = 32'd0;
    if (b_q[idx_q]) begin
      addend_d = sh_out;
    end
    acc_d = acc_q + addend_d;
  end

  // Decide whether the bit being processed is the final one of this operation.
`ifdef SHIFT_MULT_EARLY_EXIT_EN
  logic [31:0] rest_d;
  always_comb begin
    rest_d = (b_q >> idx_q) >> 1;
    last_d = (idx_q == LAST_IDX) || (rest_d == 32'd0);
  end
`else
  always_comb begin
    last_d = (idx_q == LAST_IDX);
  end
`endif

  // Shifter drive: operand and bit index in RUN, forced to zero otherwise.
  always_comb begin
    sh_a = 32'd0;
    sh_s = 32'd0;
    if (state_q == S_RUN) begin
      sh_a = a_q;
      sh_s = {{(32 - CNT_W){1'b0}}, idx_q};
    end
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 32'd0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b & B_MASK;
            acc_q   <= 32'd0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (last_d) begin
            // Result is registered with the transition so it is valid in the
            // same cycle done is high.
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_mult_seq.sv
// tb_shift_mult_seq: directed bench for shift_mult_seq with a behavioural
// left shifter connected to the sh_* ports.
// It follows the DUT build: when SHIFT_MULT_EARLY_EXIT_EN is defined, the
// early-exit latencies are expected instead of the full-scan ones.

module tb_shift_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] sh_a;
  logic [31:0] sh_s;
  logic [31:0] sh_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  shift_mult_seq #(.N_BITS(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sh_a      (sh_a),
    .sh_s      (sh_s),
    .sh_out    (sh_out),
    .dbg_state (dbg_state)
  );

  // external combinational shifter
  assign sh_out = sh_a << sh_s[4:0];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_sh_a"}, sh_a, 32'd0);
    chk({tag, "_sh_s"}, sh_s, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // One operation. lat counts edges from the start-sampling edge to done.
  // pulse_n >= 0 raises start (with op 1*1) at RUN index pulse_n;
  // pulse_done raises start in the done cycle. Both must be ignored.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat,
                        input int pulse_n, input bit pulse_done);
    int n;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    // later operand changes must not matter
    op_a  = ~a;
    op_b  = ~b;
    n = 0;
    while (!done && n < 100) begin
      chk({tag, "_run_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_run_state"}, {30'd0, dbg_state}, 32'd1);
      chk({tag, "_run_sh_a"}, sh_a, a);
      chk({tag, "_run_sh_s"}, sh_s, n);
      if (n == pulse_n) begin
        op_a  = 32'd1;
        op_b  = 32'd1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, n + 1, lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_state"}, {30'd0, dbg_state}, 32'd2);
    chk({tag, "_done_sh_a"}, sh_a, 32'd0);
    chk({tag, "_done_sh_s"}, sh_s, 32'd0);
    if (pulse_done) begin
      op_a  = 32'd1;
      op_b  = 32'd1;
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk_idle_outputs({tag, "_after"});
    chk({tag, "_held"}, result, exp_res);
    if (pulse_done || pulse_n >= 0) begin
      // no second operation may have been started
      repeat (3) begin
        tick();
        chk_idle_outputs({tag, "_noop"});
        chk({tag, "_noop_result"}, result, exp_res);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    #12;
    chk_idle_outputs("reset");
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    run_op("mul_3x5", 32'd3, 32'd5, 32'd15, EARLY ? 4 : 33, -1, 1'b0);
    run_op("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, -1, 1'b0);
    run_op("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, EARLY ? 18 : 33, -1, 1'b0);
    run_op("mul_zero_b", 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, EARLY ? 2 : 33, -1, 1'b0);
    run_op("mul_7x6_ign", 32'd7, 32'd6, 32'd42, EARLY ? 4 : 33, EARLY ? 1 : 10, 1'b1);

    // asynchronous reset in the middle of RUN
    op_a  = 32'h0000_ABCD;
    op_b  = 32'h0000_0010;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = EARLY ? 3 : 5;
    repeat (n) tick();
    chk("abort_pre_state", {30'd0, dbg_state}, 32'd1);
    chk("abort_pre_sh_s", sh_s, n);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    chk("abort_result", result, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("abort_release");
    chk("abort_release_result", result, 32'd0);

    run_op("mul_2x2", 32'd2, 32'd2, 32'd4, EARLY ? 3 : 33, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
